// File: rtl/axi_arb.sv
// rtl/axi_arb.sv - round-robin arbiter sharing one AXI4 master port among nm upstream masters
module axi_arb #(
    parameter int nm = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [nm-1:0][7:0]   s_axi_awid,
    input  logic [nm-1:0][63:0]  s_axi_awaddr,
    input  logic [nm-1:0][7:0]   s_axi_awlen,
    input  logic [nm-1:0][2:0]   s_axi_awsize,
    input  logic [nm-1:0][1:0]   s_axi_awburst,
    input  logic [nm-1:0]        s_axi_awlock,
    input  logic [nm-1:0][3:0]   s_axi_awcache,
    input  logic [nm-1:0][2:0]   s_axi_awprot,
    input  logic [nm-1:0][3:0]   s_axi_awqos,
    input  logic [nm-1:0]        s_axi_awvalid,
    output logic [nm-1:0]        s_axi_awready,

    input  logic [nm-1:0][63:0]  s_axi_wdata,
    input  logic [nm-1:0][7:0]   s_axi_wstrb,
    input  logic [nm-1:0]        s_axi_wlast,
    input  logic [nm-1:0]        s_axi_wvalid,
    output logic [nm-1:0]        s_axi_wready,

    output logic [nm-1:0][7:0]   s_axi_bid,
    output logic [nm-1:0][1:0]   s_axi_bresp,
    output logic [nm-1:0]        s_axi_bvalid,
    input  logic [nm-1:0]        s_axi_bready,

    input  logic [nm-1:0][7:0]   s_axi_arid,
    input  logic [nm-1:0][63:0]  s_axi_araddr,
    input  logic [nm-1:0][7:0]   s_axi_arlen,
    input  logic [nm-1:0][2:0]   s_axi_arsize,
    input  logic [nm-1:0][1:0]   s_axi_arburst,
    input  logic [nm-1:0]        s_axi_arlock,
    input  logic [nm-1:0][3:0]   s_axi_arcache,
    input  logic [nm-1:0][2:0]   s_axi_arprot,
    input  logic [nm-1:0][3:0]   s_axi_arqos,
    input  logic [nm-1:0]        s_axi_arvalid,
    output logic [nm-1:0]        s_axi_arready,

    output logic [nm-1:0][7:0]   s_axi_rid,
    output logic [nm-1:0][63:0]  s_axi_rdata,
    output logic [nm-1:0][1:0]   s_axi_rresp,
    output logic [nm-1:0]        s_axi_rlast,
    output logic [nm-1:0]        s_axi_rvalid,
    input  logic [nm-1:0]        s_axi_rready,

    output logic [7:0]           m_axi_awid,
    output logic [63:0]          m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awlock,
    output logic [3:0]           m_axi_awcache,
    output logic [2:0]           m_axi_awprot,
    output logic [3:0]           m_axi_awqos,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,

    output logic [63:0]          m_axi_wdata,
    output logic [7:0]           m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,

    input  logic [7:0]           m_axi_bid,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,

    output logic [7:0]           m_axi_arid,
    output logic [63:0]          m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arlock,
    output logic [3:0]           m_axi_arcache,
    output logic [2:0]           m_axi_arprot,
    output logic [3:0]           m_axi_arqos,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,

    input  logic [7:0]           m_axi_rid,
    input  logic [63:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    localparam int iw = (nm > 1) ? $clog2(nm) : 1;
    typedef logic [iw-1:0] idx_t;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    // First requester at or above ptr wins; otherwise wrap to the lowest one below ptr.
    function automatic idx_t pick(input logic [nm-1:0] req, input idx_t ptr);
        idx_t hi;
        idx_t lo;
        logic hi_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        for (int i = nm - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (idx_t'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi       = idx_t'(i);
                end else begin
                    lo = idx_t'(i);
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

    function automatic idx_t next_ptr(input idx_t g);
        return (int'(g) == nm - 1) ? '0 : g + idx_t'(1);
    endfunction

    rstate_t rstate, rstate_nx;
    idx_t    rg, rg_nx, rptr, rptr_nx;
    wstate_t wstate, wstate_nx;
    idx_t    wg, wg_nx, wptr, wptr_nx;

    // Read path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate <= R_IDLE;
            rg     <= '0;
            rptr   <= '0;
        end else begin
            rstate <= rstate_nx;
            rg     <= rg_nx;
            rptr   <= rptr_nx;
        end
    end

    always_comb begin
        rstate_nx     = rstate;
        rg_nx         = rg;
        rptr_nx       = rptr;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        case (rstate)
            R_IDLE: begin
                if (|s_axi_arvalid) begin
                    rg_nx     = pick(s_axi_arvalid, rptr);
                    rstate_nx = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axi_arvalid     = 1'b1;
                s_axi_arready[rg] = m_axi_arready;
                if (m_axi_arready) rstate_nx = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid[rg] = m_axi_rvalid;
                m_axi_rready     = s_axi_rready[rg];
                if (m_axi_rvalid && s_axi_rready[rg] && m_axi_rlast) begin
                    rstate_nx = R_IDLE;
                    rptr_nx   = next_ptr(rg);
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    assign m_axi_arid    = s_axi_arid[rg];
    assign m_axi_araddr  = s_axi_araddr[rg];
    assign m_axi_arlen   = s_axi_arlen[rg];
    assign m_axi_arsize  = s_axi_arsize[rg];
    assign m_axi_arburst = s_axi_arburst[rg];
    assign m_axi_arlock  = s_axi_arlock[rg];
    assign m_axi_arcache = s_axi_arcache[rg];
    assign m_axi_arprot  = s_axi_arprot[rg];
    assign m_axi_arqos   = s_axi_arqos[rg];

    // Response payload is broadcast; only the grantee's valid qualifies it.
    assign s_axi_rid   = {nm{m_axi_rid}};
    assign s_axi_rdata = {nm{m_axi_rdata}};
    assign s_axi_rresp = {nm{m_axi_rresp}};
    assign s_axi_rlast = {nm{m_axi_rlast}};

    // Write path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_IDLE;
            wg     <= '0;
            wptr   <= '0;
        end else begin
            wstate <= wstate_nx;
            wg     <= wg_nx;
            wptr   <= wptr_nx;
        end
    end

    always_comb begin
        wstate_nx     = wstate;
        wg_nx         = wg;
        wptr_nx       = wptr;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        case (wstate)
            W_IDLE: begin
                if (|s_axi_awvalid) begin
                    wg_nx     = pick(s_axi_awvalid, wptr);
                    wstate_nx = W_ADDR;
                end
            end
            W_ADDR: begin
                m_axi_awvalid     = 1'b1;
                s_axi_awready[wg] = m_axi_awready;
                if (m_axi_awready) wstate_nx = W_DATA;
            end
            W_DATA: begin
                m_axi_wvalid     = s_axi_wvalid[wg];
                s_axi_wready[wg] = m_axi_wready;
                if (s_axi_wvalid[wg] && m_axi_wready && s_axi_wlast[wg]) wstate_nx = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid[wg] = m_axi_bvalid;
                m_axi_bready     = s_axi_bready[wg];
                if (m_axi_bvalid && s_axi_bready[wg]) begin
                    wstate_nx = W_IDLE;
                    wptr_nx   = next_ptr(wg);
                end
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    assign m_axi_awid    = s_axi_awid[wg];
    assign m_axi_awaddr  = s_axi_awaddr[wg];
    assign m_axi_awlen   = s_axi_awlen[wg];
    assign m_axi_awsize  = s_axi_awsize[wg];
    assign m_axi_awburst = s_axi_awburst[wg];
    assign m_axi_awlock  = s_axi_awlock[wg];
    assign m_axi_awcache = s_axi_awcache[wg];
    assign m_axi_awprot  = s_axi_awprot[wg];
    assign m_axi_awqos   = s_axi_awqos[wg];
    assign m_axi_wdata   = s_axi_wdata[wg];
    assign m_axi_wstrb   = s_axi_wstrb[wg];
    assign m_axi_wlast   = s_axi_wlast[wg];

    assign s_axi_bid   = {nm{m_axi_bid}};
    assign s_axi_bresp = {nm{m_axi_bresp}};

endmodule

// File: tb/tb_axi_arb.sv
// tb/tb_axi_arb.sv - directed self-checking bench for axi_arb with two upstream masters
module tb_axi_arb;
    localparam int nm = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [nm-1:0][7:0]  s_axi_awid, s_axi_awlen, s_axi_wstrb, s_axi_bid;
    logic [nm-1:0][63:0] s_axi_awaddr, s_axi_wdata;
    logic [nm-1:0][2:0]  s_axi_awsize, s_axi_awprot;
    logic [nm-1:0][1:0]  s_axi_awburst, s_axi_bresp;
    logic [nm-1:0][3:0]  s_axi_awcache, s_axi_awqos;
    logic [nm-1:0]       s_axi_awlock, s_axi_awvalid, s_axi_awready;
    logic [nm-1:0]       s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [nm-1:0]       s_axi_bvalid, s_axi_bready;
    logic [nm-1:0][7:0]  s_axi_arid, s_axi_arlen, s_axi_rid;
    logic [nm-1:0][63:0] s_axi_araddr, s_axi_rdata;
    logic [nm-1:0][2:0]  s_axi_arsize, s_axi_arprot;
    logic [nm-1:0][1:0]  s_axi_arburst, s_axi_rresp;
    logic [nm-1:0][3:0]  s_axi_arcache, s_axi_arqos;
    logic [nm-1:0]       s_axi_arlock, s_axi_arvalid, s_axi_arready;
    logic [nm-1:0]       s_axi_rlast, s_axi_rvalid, s_axi_rready;

    logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_wstrb, m_axi_bid;
    logic [63:0] m_axi_awaddr, m_axi_wdata;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst, m_axi_bresp;
    logic [3:0]  m_axi_awcache, m_axi_awqos;
    logic        m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [7:0]  m_axi_arid, m_axi_arlen, m_axi_rid;
    logic [63:0] m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst, m_axi_rresp;
    logic [3:0]  m_axi_arcache, m_axi_arqos;
    logic        m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int errors = 0;
    int checks = 0;
    int fwd;
    int exp_g;

    axi_arb #(.nm(nm)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = '0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = '0; s_axi_wvalid = '0;
        s_axi_bready = '0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arlock = '0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = '0; s_axi_rready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    endtask

    initial begin
        // Reset with every valid and ready driven high
        rst_n = 1'b0;
        clear_inputs();
        s_axi_awvalid = '1; s_axi_wvalid = '1; s_axi_arvalid = '1;
        s_axi_bready = '1; s_axi_rready = '1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b1; m_axi_rvalid = 1'b1;
        cyc(); cyc(); #1;
        chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_m_wvalid",  64'(m_axi_wvalid),  64'd0);
        chk("rst_m_rready",  64'(m_axi_rready),  64'd0);
        chk("rst_m_bready",  64'(m_axi_bready),  64'd0);
        chk("rst_s_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_s_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_s_wready",  64'(s_axi_wready),  64'd0);
        chk("rst_s_rvalid",  64'(s_axi_rvalid),  64'd0);
        chk("rst_s_bvalid",  64'(s_axi_bvalid),  64'd0);
        rst_n = 1'b1; #1;
        chk("rel_arvalid_before_edge", 64'(m_axi_arvalid), 64'd0);
        cyc(); #1;
        chk("rel_arvalid_after_edge", 64'(m_axi_arvalid), 64'd1);
        chk("rel_grant_m0", 64'(s_axi_arready), 64'd1);
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single read from master 1, four beats
        s_axi_arvalid = 2'b10; s_axi_araddr[1] = 64'h8000_1000; s_axi_arlen[1] = 8'd3; s_axi_arid[1] = 8'd5;
        s_axi_rready = 2'b11;
        cyc(); #1;
        chk("rd_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("rd_araddr", m_axi_araddr, 64'h8000_1000);
        chk("rd_arlen", 64'(m_axi_arlen), 64'd3);
        chk("rd_arid", 64'(m_axi_arid), 64'd5);
        chk("rd_arready_stall", 64'(s_axi_arready), 64'd0);
        m_axi_arready = 1'b1; #1;
        chk("rd_arready", 64'(s_axi_arready), 64'b10);
        cyc();
        s_axi_arvalid = '0; m_axi_arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'd5; m_axi_rdata = 64'h1000 + 64'(b); m_axi_rlast = (b == 3);
            #1;
            chk("rd_rvalid", 64'(s_axi_rvalid), 64'b10);
            chk("rd_rdata", s_axi_rdata[1], 64'h1000 + 64'(b));
            chk("rd_rlast", 64'(s_axi_rlast[1]), 64'(b == 3));
            chk("rd_rid", 64'(s_axi_rid[1]), 64'd5);
            chk("rd_m_rready", 64'(m_axi_rready), 64'd1);
            cyc();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; #1;
        chk("rd_done_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rd_done_rptr", 64'(dut.rptr), 64'd0);

        // Round robin: both masters request continuously, expect 0,1,0,1
        s_axi_arvalid = 2'b11;
        s_axi_araddr[0] = 64'hA0; s_axi_araddr[1] = 64'hB0; s_axi_arlen = '0;
        m_axi_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            cyc(); #1;
            chk("rr_araddr", m_axi_araddr, 64'hA0 + 64'(exp_g) * 64'h10);
            chk("rr_arready", 64'(s_axi_arready), 64'(1 << exp_g));
            cyc();
            m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 64'(i); #1;
            chk("rr_rvalid", 64'(s_axi_rvalid), 64'(1 << exp_g));
            cyc();
            m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
            if (i == 3) s_axi_arvalid = '0;
            #1;
            chk("rr_dead_cycle", 64'(m_axi_arvalid), 64'd0);
        end
        m_axi_arready = 1'b0;
        cyc();

        // Write from master 0 with 3 stall cycles per beat
        s_axi_awvalid = 2'b01; s_axi_awaddr[0] = 64'h2000; s_axi_awlen[0] = 8'd1; s_axi_awid[0] = 8'd7;
        s_axi_wvalid = 2'b01; s_axi_wdata[0] = 64'hD0; s_axi_wlast[0] = 1'b0; s_axi_wstrb[0] = 8'hFF;
        s_axi_bready = 2'b01;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        cyc(); #1;
        chk("wr_awvalid", 64'(m_axi_awvalid), 64'd1);
        chk("wr_awaddr", m_axi_awaddr, 64'h2000);
        chk("wr_awid", 64'(m_axi_awid), 64'd7);
        chk("wr_awready", 64'(s_axi_awready), 64'b01);
        chk("wr_early_wready", 64'(s_axi_wready), 64'd0);
        chk("wr_early_wvalid", 64'(m_axi_wvalid), 64'd0);
        fwd = 0;
        for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 4; s++) begin
                cyc();
                s_axi_awvalid = '0; m_axi_awready = 1'b0;
                s_axi_wdata[0] = 64'hD0 + 64'(b); s_axi_wlast[0] = (b == 1);
                m_axi_wready = (s == 3);
                #1;
                chk("wr_m_wvalid", 64'(m_axi_wvalid), 64'd1);
                chk("wr_s_wready", 64'(s_axi_wready), (s == 3) ? 64'b01 : 64'd0);
                if (m_axi_wvalid && m_axi_wready) begin
                    chk("wr_wdata_order", m_axi_wdata, 64'hD0 + 64'(fwd));
                    fwd++;
                end
            end
        end
        cyc();
        s_axi_wvalid = '0; s_axi_wlast = '0; m_axi_wready = 1'b0; #1;
        chk("wr_beats", 64'(fwd), 64'd2);
        chk("wr_bvalid_wait", 64'(s_axi_bvalid), 64'd0);
        chk("wr_no_extra_w", 64'(m_axi_wvalid), 64'd0);
        cyc();
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'd2; m_axi_bid = 8'd7; #1;
        chk("wr_bvalid", 64'(s_axi_bvalid), 64'b01);
        chk("wr_bresp", 64'(s_axi_bresp[0]), 64'd2);
        chk("wr_bid", 64'(s_axi_bid[0]), 64'd7);
        chk("wr_m_bready", 64'(m_axi_bready), 64'd1);
        cyc();
        m_axi_bvalid = 1'b0; #1;
        chk("wr_wptr", 64'(dut.wptr), 64'd1);
        chk("wr_idle_awvalid", 64'(m_axi_awvalid), 64'd0);

        // Concurrent write (master 0) and read (master 1)
        s_axi_awvalid = 2'b01; s_axi_awaddr[0] = 64'h3000; s_axi_awlen[0] = 8'd0;
        s_axi_arvalid = 2'b10; s_axi_araddr[1] = 64'h4000; s_axi_arlen[1] = 8'd1;
        m_axi_awready = 1'b1; m_axi_arready = 1'b1;
        s_axi_rready = 2'b11; s_axi_bready = 2'b11;
        cyc(); #1;
        chk("cc_awready", 64'(s_axi_awready), 64'b01);
        chk("cc_arready", 64'(s_axi_arready), 64'b10);
        chk("cc_awaddr", m_axi_awaddr, 64'h3000);
        chk("cc_araddr", m_axi_araddr, 64'h4000);
        cyc();
        s_axi_awvalid = '0; s_axi_arvalid = '0; m_axi_awready = 1'b0; m_axi_arready = 1'b0;
        s_axi_wvalid = 2'b01; s_axi_wdata[0] = 64'hAA; s_axi_wlast[0] = 1'b1; m_axi_wready = 1'b1;
        m_axi_rvalid = 1'b1; m_axi_rdata = 64'h55; m_axi_rlast = 1'b0; m_axi_rid = 8'd9;
        #1;
        chk("cc_wready", 64'(s_axi_wready), 64'b01);
        chk("cc_wdata", m_axi_wdata, 64'hAA);
        chk("cc_rvalid1", 64'(s_axi_rvalid), 64'b10);
        chk("cc_rdata1", s_axi_rdata[1], 64'h55);
        cyc();
        s_axi_wvalid = '0; s_axi_wlast = '0; m_axi_wready = 1'b0;
        m_axi_rdata = 64'h56; m_axi_rlast = 1'b1;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0; m_axi_bid = 8'd3;
        #1;
        chk("cc_bvalid", 64'(s_axi_bvalid), 64'b01);
        chk("cc_rvalid2", 64'(s_axi_rvalid), 64'b10);
        chk("cc_rlast2", 64'(s_axi_rlast[1]), 64'd1);
        chk("cc_no_dup_w", 64'(m_axi_wvalid), 64'd0);
        cyc();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_bvalid = 1'b0; #1;
        chk("cc_done_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("cc_done_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("cc_rptr", 64'(dut.rptr), 64'd0);
        chk("cc_wptr", 64'(dut.wptr), 64'd1);

        // Reset in the middle of a 4-beat read from master 1
        s_axi_arvalid = 2'b10; s_axi_araddr[1] = 64'h5000; s_axi_arlen[1] = 8'd3;
        m_axi_arready = 1'b1;
        cyc(); #1;
        chk("mr_arready", 64'(s_axi_arready), 64'b10);
        cyc();
        s_axi_arvalid = '0; m_axi_arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = 64'h5000 + 64'(b); m_axi_rlast = 1'b0; #1;
            chk("mr_rvalid", 64'(s_axi_rvalid), 64'b10);
            if (b < 2) cyc();
        end
        s_axi_arvalid = 2'b10;
        rst_n = 1'b0; #1;
        chk("mr_async_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("mr_async_rready", 64'(m_axi_rready), 64'd0);
        chk("mr_async_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("mr_async_wptr", 64'(dut.wptr), 64'd0);
        m_axi_rvalid = 1'b0; m_axi_arready = 1'b1;
        cyc();
        rst_n = 1'b1; #1;
        chk("mr_rel_arvalid", 64'(m_axi_arvalid), 64'd0);
        cyc(); #1;
        chk("mr_new_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("mr_new_araddr", m_axi_araddr, 64'h5000);
        chk("mr_new_arready", 64'(s_axi_arready), 64'b10);
        cyc();
        s_axi_arvalid = '0; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; #1;
        chk("mr_new_rvalid", 64'(s_axi_rvalid), 64'b10);
        cyc();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; #1;
        chk("mr_new_rptr", 64'(dut.rptr), 64'd0);
        chk("mr_new_idle", 64'(m_axi_arvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
